// File: rtl/id_ex_skid_reg_pkg.sv
// Shared constants for the ID/EX boundary: field widths, extension-select codes, NOP control.
// Optional stall counter in the top is enabled by IDEX_STALL_CNT_EN.
package id_ex_skid_reg_pkg;

    localparam int N          = 31;
    localparam int ILEN       = 32;
    localparam int JLEN       = 26;
    localparam int CTRL_W_DEF = 16;
    localparam int PC_W_DEF   = N + 1;

    // Extension select codes consumed by the 16-to-32 extender; any other value means signed.
    localparam logic [1:0] EXT_SIGN = 2'b00;
    localparam logic [1:0] EXT_UNSI = 2'b01;
    localparam logic [1:0] EXT_LUI  = 2'b10;
    localparam logic [1:0] EXT_SA   = 2'b11;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

    // Fixed-width part of the held payload; PC and control are parameterised and sit around it.
    typedef struct packed {
        logic [ILEN-1:0] instr;
        logic [1:0]      ext_sel;
        logic [31:0]     rs_data;
        logic [31:0]     rt_data;
    } op_t;

    function automatic logic [15:0] imm16_of(input logic [ILEN-1:0] instr);
        return instr[15:0];
    endfunction

    function automatic logic [JLEN-1:0] imm26_of(input logic [ILEN-1:0] instr);
        return instr[JLEN-1:0];
    endfunction

endpackage

// File: rtl/id_ex_skid_reg_slot.sv
// idex_slot: one valid+payload register; clear beats load, payload only written on load.
// Latency 1 cycle; no backpressure of its own (the parent decides load/clear).
// Flow control is entirely the parent's responsibility.
module idex_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         valid,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            q     <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            q     <= d;
        end
    end

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with one-entry skid buffer; optional stall counter via IDEX_STALL_CNT_EN.
// Latency 1 cycle ID->EX without back-pressure.
// Backpressure: id_ready is a flop (= !skid valid), so EX stalls never reach ID combinationally.
module id_ex_skid_reg
    import id_ex_skid_reg_pkg::*;
#(
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int PC_W   = PC_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [PC_W-1:0]   id_pc,
    input  logic [ILEN-1:0]   id_instr,
    input  logic [1:0]        id_ext_sel,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [CTRL_W-1:0] id_ctrl,
`ifdef IDEX_STALL_CNT_EN
    output logic [31:0]       stall_cnt,
`endif
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [PC_W-1:0]   ex_pc,
    output logic [15:0]       ex_imm16,
    output logic [JLEN-1:0]   ex_imm26,
    output logic [1:0]        ex_ext_sel,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [CTRL_W-1:0] ex_ctrl
);

    localparam int W = PC_W + $bits(op_t) + CTRL_W;

    logic          m_valid, s_valid;
    logic [W-1:0]  m_q, s_q, m_d, id_pack;
    logic          accept, drain, main_free;
    logic          m_load, m_clear, s_load, s_clear;
    op_t           id_op, m_op;
    logic [CTRL_W-1:0] m_ctrl;

    always_comb begin
        id_op         = '0;
        id_op.instr   = id_instr;
        id_op.ext_sel = id_ext_sel;
        id_op.rs_data = id_rs_data;
        id_op.rt_data = id_rt_data;
    end

    assign id_pack   = {id_pc, id_op, id_ctrl};
    assign id_ready  = ~s_valid;
    assign accept    = id_valid & id_ready;
    assign drain     = m_valid & ex_ready;
    assign main_free = ~m_valid | drain;

    // Skid entry always refills main first so ordering stays FIFO.
    assign m_d     = s_valid ? s_q : id_pack;
    assign m_load  = ~flush & main_free & (s_valid | accept);
    assign m_clear = flush | (main_free & ~s_valid & ~accept);
    assign s_load  = ~flush & ~main_free & accept;
    assign s_clear = flush | (main_free & s_valid);

    idex_slot #(.W(W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (m_load),
        .clear (m_clear),
        .d     (m_d),
        .valid (m_valid),
        .q     (m_q)
    );

    idex_slot #(.W(W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (s_load),
        .clear (s_clear),
        .d     (id_pack),
        .valid (s_valid),
        .q     (s_q)
    );

    assign {ex_pc, m_op, m_ctrl} = m_q;

    assign ex_valid   = m_valid;
    assign ex_imm16   = imm16_of(m_op.instr);
    assign ex_imm26   = imm26_of(m_op.instr);
    assign ex_ext_sel = m_op.ext_sel;
    assign ex_rs_data = m_op.rs_data;
    assign ex_rt_data = m_op.rt_data;
    // A bubble must look like a NOP downstream.
    assign ex_ctrl    = m_valid ? m_ctrl : {CTRL_W{1'b0}};

`ifdef IDEX_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (m_valid && !ex_ready && stall_cnt != 32'hFFFF_FFFF) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_skid_reg.sv
// Bench for id_ex_skid_reg: directed scenarios plus random traffic against a queue model.
// Stall counter checks are compiled in with IDEX_STALL_CNT_EN.
module tb_id_ex_skid_reg;
    import id_ex_skid_reg_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, id_valid, id_ready, ex_valid, ex_ready;
    logic [31:0] id_pc, id_instr, id_rs_data, id_rt_data;
    logic [1:0]  id_ext_sel, ex_ext_sel;
    logic [15:0] id_ctrl, ex_ctrl, ex_imm16;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data;
    logic [25:0] ex_imm26;
`ifdef IDEX_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_skid_reg dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_ext_sel (id_ext_sel),
        .id_rs_data (id_rs_data),
        .id_rt_data (id_rt_data),
        .id_ctrl    (id_ctrl),
`ifdef IDEX_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .ex_valid   (ex_valid),
        .ex_ready   (ex_ready),
        .ex_pc      (ex_pc),
        .ex_imm16   (ex_imm16),
        .ex_imm26   (ex_imm26),
        .ex_ext_sel (ex_ext_sel),
        .ex_rs_data (ex_rs_data),
        .ex_rt_data (ex_rt_data),
        .ex_ctrl    (ex_ctrl)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [1:0]  ext;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] ctrl;
    } ent_t;

    ent_t        q[$];          // model: in-order entries held by the block, capacity 2
    logic [31:0] exp_stall;
    int          tests = 0;
    int          fails = 0;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ex_valid"}, 64'(ex_valid), 64'(q.size() > 0));
        chk({tag, ".id_ready"}, 64'(id_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            chk({tag, ".ex_pc"},   64'(ex_pc),      64'(q[0].pc));
            chk({tag, ".imm16"},   64'(ex_imm16),   64'(q[0].instr[15:0]));
            chk({tag, ".imm26"},   64'(ex_imm26),   64'(q[0].instr[25:0]));
            chk({tag, ".ext_sel"}, 64'(ex_ext_sel), 64'(q[0].ext));
            chk({tag, ".rs"},      64'(ex_rs_data), 64'(q[0].rs));
            chk({tag, ".rt"},      64'(ex_rt_data), 64'(q[0].rt));
            chk({tag, ".ctrl"},    64'(ex_ctrl),    64'(q[0].ctrl));
        end else begin
            chk({tag, ".ctrl_nop"}, 64'(ex_ctrl), 64'd0);
        end
`ifdef IDEX_STALL_CNT_EN
        chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(exp_stall));
`endif
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                          input logic [1:0] ext);
        id_valid   = v;
        id_pc      = pc;
        id_instr   = instr;
        id_ext_sel = ext;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_ctrl    = 16'($urandom_range(1, 16'hFFFF));
    endtask

    // Called just after a falling edge with inputs already set; advances one clock.
    task automatic cycle(input string tag);
        bit   acc, drn;
        ent_t e;
        acc = id_valid && (q.size() < 2);
        drn = (q.size() > 0) && ex_ready;
        e   = '{id_pc, id_instr, id_ext_sel, id_rs_data, id_rt_data, id_ctrl};
        if (q.size() > 0 && !ex_ready && exp_stall != 32'hFFFF_FFFF) exp_stall++;
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        @(negedge clk);
        check_all(tag);
    endtask

    logic [31:0] snap_pc, snap_rs;
    logic [15:0] snap_ctrl;

    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b0; exp_stall = '0;
        set_in(1'b0, '0, '0, EXT_SIGN);
        @(negedge clk);
        @(negedge clk);
        chk("rst.ex_valid", 64'(ex_valid), 64'd0);
        chk("rst.ex_pc",    64'(ex_pc),    64'd0);
        chk("rst.ex_ctrl",  64'(ex_ctrl),  64'd0);
        chk("rst.id_ready", 64'(id_ready), 64'd1);
        rst = 1'b0;

        // Single instruction, no back-pressure
        ex_ready = 1'b1;
        set_in(1'b1, 32'h40, 32'h2408FFFF, EXT_SIGN);
        cycle("first");
        chk("first.valid", 64'(ex_valid),   64'd1);
        chk("first.imm16", 64'(ex_imm16),   64'hFFFF);
        chk("first.ext",   64'(ex_ext_sel), 64'(EXT_SIGN));
        id_valid = 1'b0;
        cycle("first_drain");

        // Back-pressure with three back-to-back inputs
        ex_ready = 1'b0;
        set_in(1'b1, 32'h100, $urandom, 2'($urandom)); cycle("bp0");
        set_in(1'b1, 32'h104, $urandom, 2'($urandom)); cycle("bp1");
        chk("bp.rdy_low", 64'(id_ready), 64'd0);
        chk("bp.main",    64'(ex_pc),    64'h100);
        set_in(1'b1, 32'h108, $urandom, 2'($urandom)); cycle("bp2");
        chk("bp.hold", 64'(ex_pc), 64'h100);
        ex_ready = 1'b1;
        cycle("dr0");
        chk("dr0.pc", 64'(ex_pc), 64'h104);
        cycle("dr1");
        chk("dr1.pc", 64'(ex_pc), 64'h108);
        id_valid = 1'b0;
        cycle("dr2");
        chk("dr2.empty", 64'(ex_valid), 64'd0);

        // Flush with both slots full and new input pending
        ex_ready = 1'b0;
        set_in(1'b1, 32'h200, $urandom, 2'($urandom)); cycle("fl0");
        set_in(1'b1, 32'h204, $urandom, 2'($urandom)); cycle("fl1");
        set_in(1'b1, 32'h208, $urandom, 2'($urandom));
        flush = 1'b1;
        cycle("flush");
        chk("flush.valid", 64'(ex_valid), 64'd0);
        chk("flush.ctrl",  64'(ex_ctrl),  64'd0);
        chk("flush.rdy",   64'(id_ready), 64'd1);
        flush = 1'b0; id_valid = 1'b0;
        cycle("post_flush");
        chk("post_flush.valid", 64'(ex_valid), 64'd0);

        // Asynchronous reset mid-cycle while holding a valid entry
        set_in(1'b1, 32'h300, $urandom, 2'($urandom)); cycle("pre_rst");
        id_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst.valid", 64'(ex_valid),   64'd0);
        chk("arst.pc",    64'(ex_pc),      64'd0);
        chk("arst.rs",    64'(ex_rs_data), 64'd0);
        chk("arst.ctrl",  64'(ex_ctrl),    64'd0);
        chk("arst.rdy",   64'(id_ready),   64'd1);
        q.delete(); exp_stall = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        check_all("post_rst");

        // J-type hold for 5 stalled cycles
        set_in(1'b1, 32'h400, 32'h0BFFFFFF, EXT_SIGN); cycle("jload");
        chk("j.imm26", 64'(ex_imm26), 64'h3FFFFFF);
        chk("j.imm16", 64'(ex_imm16), 64'hFFFF);
        snap_pc = ex_pc; snap_rs = ex_rs_data; snap_ctrl = ex_ctrl;
        id_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle("jhold");
            chk("jhold.pc",   64'(ex_pc),      64'(snap_pc));
            chk("jhold.rs",   64'(ex_rs_data), 64'(snap_rs));
            chk("jhold.ctrl", 64'(ex_ctrl),    64'(snap_ctrl));
        end
`ifdef IDEX_STALL_CNT_EN
        chk("j.stall_cnt", 64'(stall_cnt), 64'd5);
`endif

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom, $urandom, 2'($urandom));
            ex_ready = $urandom_range(0, 2) != 0;
            flush    = $urandom_range(0, 19) == 0;
            cycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
Name: id_ex_skid_reg

Overview:
- ID/EX pipeline boundary register with a valid/ready handshake and a one-entry skid buffer.
- Captures the decoded instruction fields from ID and drives the EX stage.
- Feeds the EX immediate-extension units:
  - imm16 with its 2-bit extension select goes to the 16-to-32 extender.
  - imm26 goes to the 26-to-32 jump extender.
- Absorbs EX back-pressure (multi-cycle EX ops) without a combinational ready path back into ID.

Parameters:
- CTRL_W, 16, width of the opaque decoded-control bundle; all-zero means NOP/bubble.
- PC_W, 32, PC width; equals `N+1.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of both held entries (branch/jump redirect).
- id_valid  in  1  ID presents a valid instruction.
- id_ready  out  1  block can accept this cycle; registered (= !skid_valid).
- id_pc  in  PC_W  PC of the instruction.
- id_instr  in  32  raw instruction word.
- id_ext_sel  in  2  extension select: `Ext_unsi, `Ext_lui, `Ext_sa, others = signed.
- id_rs_data  in  32  rs operand.
- id_rt_data  in  32  rt operand.
- id_ctrl  in  CTRL_W  decoded control bundle.
- ex_valid  out  1  EX entry valid.
- ex_ready  in  1  EX consumes the entry this cycle.
- ex_pc  out  PC_W  held PC.
- ex_imm16  out  16  instr[15:0].
- ex_imm26  out  26  instr[25:0].
- ex_ext_sel  out  2  held extension select.
- ex_rs_data  out  32  held rs operand.
- ex_rt_data  out  32  held rt operand.
- ex_ctrl  out  CTRL_W  held control; forced 0 when ex_valid=0.

Behaviour:
- State: main slot (M_valid, M_data) drives ex_*; skid slot (S_valid, S_data).
- Reset, asynchronous: M_valid=S_valid=0 and all data 0. Result: ex_valid=0, every ex_* output 0, id_ready=1.
- Accept = id_valid & id_ready. Drain = ex_valid & ex_ready. Latency ID→EX is 1 cycle when there is no back-pressure.
- Each rising edge, with flush=0:
  - Main slot is free when M_valid=0 or Drain=1.
  - Main free and S_valid=1: main loads the skid slot, S_valid→0. A simultaneous Accept is impossible because id_ready=0.
  - Main free, S_valid=0 and Accept: main loads the ID inputs, M_valid→1.
  - Main free and nothing to load: M_valid→0.
  - Main not free and Accept: the ID inputs go to the skid slot, S_valid→1.
- Ordering: strict FIFO; the skid entry always precedes newer input.
- Flush=1 (priority over everything): M_valid→0 and S_valid→0. ID input in the same cycle is discarded. id_ready=1 the next cycle.
- Reset mid-operation: held entries are lost immediately; no partial outputs.
- ex_ctrl is gated to 0 whenever ex_valid=0, so a bubble reads as a NOP.
- ex_imm16 and ex_imm26 are pure field slices of the held instruction. No extension is done here; the downstream extenders do it.
- Data regs update only on load, so there is no toggling while stalled. Holding ex_* stable while ex_valid=1 and ex_ready=0 is mandatory.

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt [31:0]: increments each cycle with ex_valid=1 and ex_ready=0.
  - Saturates at 0xFFFFFFFF. Resets to 0 on rst. Not cleared by flush.
- Undefined: the port and counter are absent; behaviour otherwise identical.

Decomposition:
- define.v holds:
  - `N, `Ilen, `Jlen.
  - The `Ext_* codes.
  - A new `CTRL_W default.
  - A new `NOP_CTRL (all zero).
- One natural sub-module: idex_slot, a valid+payload register with load/clear/async reset. It is instantiated twice (main, skid).

Test Plan:
- Reset, then id_valid=1, id_instr=0x2408FFFF, id_ext_sel=signed, ex_ready=1 → next cycle ex_valid=1, ex_imm16=0xFFFF, ex_ext_sel=signed.
- ex_ready=0 with 3 back-to-back inputs (pc 0x100, 0x104, 0x108):
  - 0x100 holds in main; 0x104 is captured in the skid slot; id_ready drops.
  - 0x108 is held by ID.
  - When ex_ready=1, EX drains 0x100, 0x104, 0x108 in order with no loss or duplicate.
- Flush asserted while both slots are full and id_valid=1 → next cycle ex_valid=0, ex_ctrl=0, id_ready=1; the new instruction is not captured.
- Async rst pulsed mid-clock with ex_valid=1 → ex_valid and all outputs are 0 before the next edge. Normal operation resumes after release.
- J-type instr 0x0BFFFFFF → ex_imm26=0x3FFFFFF, ex_imm16=0xFFFF. ex_ready held 0 for 5 cycles → outputs stable. With IDEX_STALL_CNT_EN, stall_cnt=5.
